// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard control for the 5-stage RV32I core. Generates
//            IF/ID stall, IF/ID and ID/EX flush, and per-source operand
//            forwarding selects. A small FSM sequences load-use bubbles and
//            the ECALL drain / halt / resume handshake.
// Ports    : clk, rst (async, active-high)
//            id_*   : source fields / ECALL flag of the instruction in ID
//            ex_*   : rd, write-enable, load flag and taken-branch of EX
//            mem_*  : rd / write-enable of MEM;  wb_* : rd / write-enable of WB
//            ecall_ack : environment finished servicing the ECALL
//            stall_if, stall_id, flush_id, flush_ex : pipeline controls
//            fwd_rs1_sel, fwd_rs2_sel : 0 regfile, 1 EX, 2 MEM, 3 WB
//            halt : registered, high while the core waits on ECALL service
// Options  : define HAZARD_PERF_EN to add saturating counters
//            perf_stall_cyc / perf_flush_cnt (CNT_W bits each).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       id_ecall,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_wb_en,
    input  logic       ex_is_load,
    input  logic       ex_br_taken,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_wb_en,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_wb_en,
    input  logic       ecall_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       flush_ex,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_t;

    // The cycle that detects the hazard/ECALL is itself the first stall
    // cycle, so the counters are loaded one (or two) short.
    localparam logic [2:0] c_ld_init    = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;
    localparam logic [2:0] c_drain_init = 3'(DRAIN_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_halt, w_halt_nxt;

    logic       w_m1, w_m2, w_luh;
    logic       w_stall_if, w_stall_id, w_flush_id, w_flush_ex;

    assign w_m1  = id_rs1_used && (id_rs1_addr != 5'd0);
    assign w_m2  = id_rs2_used && (id_rs2_addr != 5'd0);
    assign w_luh = ex_is_load && ex_wb_en && (ex_rd_addr != 5'd0) &&
                   ((w_m1 && (ex_rd_addr == id_rs1_addr)) ||
                    (w_m2 && (ex_rd_addr == id_rs2_addr)));

    // Youngest producer wins. A load in EX has no result yet, so it never
    // forwards from EX (that case is covered by the load-use stall).
    function automatic logic [1:0] fwd_sel(
        input logic       used_nz,
        input logic [4:0] src,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (used_nz) begin
            if (ex_we && !ex_ld && (ex_rd == src))
                sel = 2'd1;
            else if (mem_we && (mem_rd == src))
                sel = 2'd2;
            else if (wb_we && (wb_rd == src))
                sel = 2'd3;
        end
        return sel;
    endfunction

    assign fwd_rs1_sel = fwd_sel(w_m1, id_rs1_addr, ex_rd_addr, ex_wb_en, ex_is_load,
                                 mem_rd_addr, mem_wb_en, wb_rd_addr, wb_wb_en);
    assign fwd_rs2_sel = fwd_sel(w_m2, id_rs2_addr, ex_rd_addr, ex_wb_en, ex_is_load,
                                 mem_rd_addr, mem_wb_en, wb_rd_addr, wb_wb_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_halt_nxt  = r_halt;
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        case (r_state)
            RUN: begin
                if (ex_br_taken) begin
                    // ID holds a wrong-path instruction: its hazards are moot.
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                end else if (w_luh) begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_flush_ex = 1'b1;
                    if (LOAD_STALL > 1) begin
                        w_cnt_nxt   = c_ld_init;
                        w_state_nxt = LDSTALL;
                    end
                end else if (id_ecall) begin
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_flush_ex  = 1'b1;
                    w_cnt_nxt   = c_drain_init;
                    w_state_nxt = DRAIN;
                end
            end
            LDSTALL: begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
                if (r_cnt == 3'd0)
                    w_state_nxt = RUN;
                else
                    w_cnt_nxt = r_cnt - 3'd1;
            end
            DRAIN: begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = HALT;
                    w_halt_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            HALT: begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
                if (ecall_ack) begin
                    // Drop the serviced ECALL from IF/ID and let PC+4 fetch.
                    w_flush_id  = 1'b1;
                    w_stall_if  = 1'b0;
                    w_stall_id  = 1'b0;
                    w_halt_nxt  = 1'b0;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign stall_if = w_stall_if;
    assign stall_id = w_stall_id;
    assign flush_id = w_flush_id;
    assign flush_ex = w_flush_ex;
    assign halt     = r_halt;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_if && !r_halt && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            if ((r_state == RUN) && ex_br_taken && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + CNT_W'(1);
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl. Two instances share stimulus:
//            dut A (LOAD_STALL=1) and dut B (LOAD_STALL=3), both DRAIN_CYCLES=3.
//            Each cycle the stimulus pushes the hand-derived expected outputs
//            {stall_if,stall_id,flush_id,flush_ex,fwd1,fwd2,halt} of both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, id_ecall;
    logic       ex_wb_en, ex_is_load, ex_br_taken, mem_wb_en, wb_wb_en, ecall_ack;

    logic       a_sif, a_sid, a_fid, a_fex, a_halt;
    logic [1:0] a_f1, a_f2;
    logic       b_sif, b_sid, b_fid, b_fex, b_halt;
    logic [1:0] b_f1, b_f2;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .DRAIN_CYCLES(3), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_ecall(id_ecall),
        .ex_rd_addr(ex_rd_addr), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .mem_rd_addr(mem_rd_addr), .mem_wb_en(mem_wb_en),
        .wb_rd_addr(wb_rd_addr), .wb_wb_en(wb_wb_en), .ecall_ack(ecall_ack),
        .stall_if(a_sif), .stall_id(a_sid), .flush_id(a_fid), .flush_ex(a_fex),
        .fwd_rs1_sel(a_f1), .fwd_rs2_sel(a_f2), .halt(a_halt)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(a_pstall), .perf_flush_cnt(a_pflush)
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3), .DRAIN_CYCLES(3), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_ecall(id_ecall),
        .ex_rd_addr(ex_rd_addr), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .mem_rd_addr(mem_rd_addr), .mem_wb_en(mem_wb_en),
        .wb_rd_addr(wb_rd_addr), .wb_wb_en(wb_wb_en), .ecall_ack(ecall_ack),
        .stall_if(b_sif), .stall_id(b_sid), .flush_id(b_fid), .flush_ex(b_fex),
        .fwd_rs1_sel(b_f1), .fwd_rs2_sel(b_f2), .halt(b_halt)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(b_pstall), .perf_flush_cnt(b_pflush)
`endif
    );

    typedef struct packed {
        logic [8:0] a;
        logic [8:0] b;
        logic [7:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec   = 0;

    function automatic logic [8:0] pk(input logic sif, input logic sid, input logic fid,
                                      input logic fex, input logic [1:0] f1,
                                      input logic [1:0] f2, input logic h);
        return {sif, sid, fid, fex, f1, f2, h};
    endfunction

    task automatic set_idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_ecall = 1'b0; ex_rd_addr = 5'd0; ex_wb_en = 1'b0; ex_is_load = 1'b0;
        ex_br_taken = 1'b0; mem_rd_addr = 5'd0; mem_wb_en = 1'b0; wb_rd_addr = 5'd0;
        wb_wb_en = 1'b0; ecall_ack = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] ea, input logic [8:0] eb);
        exp_t e;
        e.a  = ea;
        e.b  = eb;
        e.id = 8'(vec);
        exp_q.push_back(e);
        vec++;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic chk_perf(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask
`endif

    // Monitor: compares both instances on the falling edge of every cycle
    // that has an outstanding expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] ga, gb;
            e  = exp_q.pop_front();
            ga = {a_sif, a_sid, a_fid, a_fex, a_f1, a_f2, a_halt};
            gb = {b_sif, b_sid, b_fid, b_fex, b_f1, b_f2, b_halt};
            n_cmp++;
            if (ga !== e.a) begin
                n_bad++;
                $display("FAIL vec%0d dutA {sif,sid,fid,fex,f1,f2,halt}: got %b want %b",
                         e.id, ga, e.a);
            end
            n_cmp++;
            if (gb !== e.b) begin
                n_bad++;
                $display("FAIL vec%0d dutB {sif,sid,fid,fex,f1,f2,halt}: got %b want %b",
                         e.id, gb, e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] z, stl, hlt;
        z   = pk(0, 0, 0, 0, 2'd0, 2'd0, 0);
        stl = pk(1, 1, 0, 1, 2'd0, 2'd0, 0);
        hlt = pk(1, 1, 0, 1, 2'd0, 2'd0, 1);

        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);

        // Reset state, then release.
        cyc(); push(z, z);
`ifdef HAZARD_PERF_EN
        chk_perf("perf_stall_reset", a_pstall, 32'd0);
        chk_perf("perf_flush_reset", a_pflush, 32'd0);
`endif
        cyc(); rst = 1'b0; push(z, z);

        // Load-use on rs1 (rd=5): A stalls 1 cycle, B stalls 3.
        cyc(); set_idle();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd5;
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        push(stl, stl);
        cyc(); set_idle();
        mem_rd_addr = 5'd5; mem_wb_en = 1'b1; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        push(pk(0, 0, 0, 0, 2'd2, 2'd0, 0), pk(1, 1, 0, 1, 2'd2, 2'd0, 0));
        cyc(); push(pk(0, 0, 0, 0, 2'd2, 2'd0, 0), pk(1, 1, 0, 1, 2'd2, 2'd0, 0));
        cyc(); push(pk(0, 0, 0, 0, 2'd2, 2'd0, 0), pk(0, 0, 0, 0, 2'd2, 2'd0, 0));

        // Load to x0 with x0 sources: no hazard, no forwarding.
        cyc(); set_idle();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd0;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        push(z, z);

        // Forwarding priority on rs2=7; rs1=7 but unused.
        cyc(); set_idle();
        ex_rd_addr = 5'd7; ex_wb_en = 1'b1; mem_rd_addr = 5'd7; mem_wb_en = 1'b1;
        wb_rd_addr = 5'd7; wb_wb_en = 1'b1;
        id_rs2_addr = 5'd7; id_rs2_used = 1'b1; id_rs1_addr = 5'd7;
        push(pk(0, 0, 0, 0, 2'd0, 2'd1, 0), pk(0, 0, 0, 0, 2'd0, 2'd1, 0));
        cyc(); ex_wb_en = 1'b0;
        push(pk(0, 0, 0, 0, 2'd0, 2'd2, 0), pk(0, 0, 0, 0, 2'd0, 2'd2, 0));
        cyc(); mem_wb_en = 1'b0;
        push(pk(0, 0, 0, 0, 2'd0, 2'd3, 0), pk(0, 0, 0, 0, 2'd0, 2'd3, 0));
        cyc(); id_rs2_addr = 5'd0;
        push(z, z);

        // Taken branch beats simultaneous load-use and ECALL.
        cyc(); set_idle();
        ex_br_taken = 1'b1; ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd_addr = 5'd5;
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1; id_ecall = 1'b1;
        push(pk(0, 0, 1, 1, 2'd0, 2'd0, 0), pk(0, 0, 1, 1, 2'd0, 2'd0, 0));
        cyc(); set_idle(); push(z, z);
`ifdef HAZARD_PERF_EN
        chk_perf("perf_flush_after_branch", a_pflush, 32'd1);
`endif

        // ECALL: 4 stall cycles, halt on the 4th edge. ack/branch ignored in DRAIN.
        cyc(); set_idle(); id_ecall = 1'b1; push(stl, stl);
        cyc(); ecall_ack = 1'b1; push(stl, stl);
        cyc(); ecall_ack = 1'b0; ex_br_taken = 1'b1; push(stl, stl);
        cyc(); ex_br_taken = 1'b0; push(stl, stl);
        for (int i = 0; i < 10; i++) begin
            cyc(); push(hlt, hlt);
        end
        cyc(); ecall_ack = 1'b1;
        push(pk(0, 0, 1, 1, 2'd0, 2'd0, 1), pk(0, 0, 1, 1, 2'd0, 2'd0, 1));
        cyc(); set_idle(); push(z, z);

        // Reset while draining (cnt=1), then a clean ECALL drain afterwards.
        cyc(); id_ecall = 1'b1; push(stl, stl);
        cyc(); push(stl, stl);
        cyc(); rst = 1'b1; set_idle(); push(z, z);
`ifdef HAZARD_PERF_EN
        chk_perf("perf_stall_midreset", a_pstall, 32'd0);
        chk_perf("perf_flush_midreset", a_pflush, 32'd0);
`endif
        cyc(); push(z, z);
        cyc(); rst = 1'b0; push(z, z);
        cyc(); id_ecall = 1'b1; push(stl, stl);
        cyc(); push(stl, stl);
        cyc(); push(stl, stl);
        cyc(); push(stl, stl);
        cyc(); push(hlt, hlt);
        cyc(); ecall_ack = 1'b1;
        push(pk(0, 0, 1, 1, 2'd0, 2'd0, 1), pk(0, 0, 1, 1, 2'd0, 2'd0, 1));
        cyc(); set_idle(); push(z, z);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core.
- Decides per cycle whether IF/ID stall, whether ID/EX are flushed, and which operand-forwarding path feeds each source register read in ID.
- Sequences load-use bubbles and the ECALL drain/halt/resume handshake through a small FSM.
- Sits beside the decoder in ID and consumes register addresses and control bits from the ID, EX, MEM and WB pipeline registers.

Parameters:
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal range 1..3.
- DRAIN_CYCLES, 3, cycles ECALL is held in ID while older instructions retire; legal range 1..7.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs1_addr  in  5  rs1 field of the instruction in ID
- id_rs2_addr  in  5  rs2 field of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_ecall  in  1  ID instruction is ECALL
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_wb_en  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch, JAL or JALR
- mem_rd_addr  in  5  rd in MEM
- mem_wb_en  in  1  MEM instruction writes rd
- wb_rd_addr  in  5  rd in WB
- wb_wb_en  in  1  WB instruction writes rd
- ecall_ack  in  1  environment has serviced the ECALL
- stall_if  out  1  hold PC
- stall_id  out  1  hold the IF/ID register
- flush_id  out  1  zero the IF/ID register (NOP)
- flush_ex  out  1  zero the ID/EX register (bubble)
- fwd_rs1_sel  out  2  0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB result
- fwd_rs2_sel  out  2  same encoding, for rs2
- halt  out  1  core halted on ECALL, registered

Behaviour:
- Clock and reset: a single clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=RUN, cnt=0, halt=0.
- Combinational outputs are derived from state and inputs. After reset they follow the RUN rules below.
- Definitions:
  - m1 = id_rs1_used & id_rs1_addr!=0; m2 likewise for rs2.
  - luh (load-use hazard) = ex_is_load & ex_wb_en & ex_rd_addr!=0 & ((m1 & ex_rd_addr==id_rs1_addr) | (m2 & ex_rd_addr==id_rs2_addr)).
- Forwarding (pure combinational, all states), for each source with mN=1:
  - EX match & ex_wb_en & !ex_is_load -> 1.
  - else MEM match & mem_wb_en -> 2.
  - else WB match & wb_wb_en -> 3.
  - else 0.
  - x0 or unused source -> 0.
  - Youngest stage wins.
- FSM states: RUN, LDSTALL, DRAIN, HALT. cnt is 3 bits.
- RUN, priority order:
  1. ex_br_taken: flush_id=1, flush_ex=1, no stall. ID is wrong-path, so luh and id_ecall are ignored this cycle. Stay RUN.
  2. luh: stall_if=stall_id=1, flush_ex=1. If LOAD_STALL>1, then cnt<=LOAD_STALL-2 and go LDSTALL; else stay RUN.
  3. id_ecall: stall_if=stall_id=1, flush_ex=1, cnt<=DRAIN_CYCLES-1, go DRAIN.
  4. else all stall/flush outputs are 0.
- LDSTALL: stall_if=stall_id=flush_ex=1. If cnt==0 go RUN, else cnt<=cnt-1.
- DRAIN: stall_if=stall_id=flush_ex=1. If cnt==0, go HALT and set halt<=1; else cnt<=cnt-1.
- HALT: stall_if=stall_id=flush_ex=1, halt=1.
  - ecall_ack=1: flush_id=1 (consume ECALL), stall_if=0, stall_id=0, halt<=0, go RUN. Fetch resumes from held PC+4.
  - ecall_ack outside HALT is ignored.
- ex_br_taken outside RUN is ignored; EX only holds bubbles there.
- Reset asserted in any state returns to RUN immediately, with halt=0.
- Total cycles per load-use = LOAD_STALL.
- Cycles from ECALL in ID to halt=1 = DRAIN_CYCLES+1.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cyc [CNT_W] and perf_flush_cnt [CNT_W], both reset to 0.
  - perf_stall_cyc increments every cycle stall_if=1 and halt=0.
  - perf_flush_cnt increments every cycle flush_id=1 due to ex_br_taken.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- EX load ex_rd=5, ID rs1=5 used, LOAD_STALL=1 -> one cycle of stall_if/stall_id/flush_ex=1, then rs1 forwarded from MEM (fwd_rs1_sel=2).
- Same hazard with LOAD_STALL=3 -> exactly 3 stall cycles, state returns to RUN. Repeat with rd=0 -> no stall.
- EX add rd=7, MEM rd=7, WB rd=7, ID rs2=7 -> fwd_rs2_sel=1. Drop EX -> 2. Drop MEM -> 3. Set ID rs2=0 -> 0.
- ex_br_taken=1 simultaneous with luh and id_ecall -> flush_id=flush_ex=1, stall=0, state stays RUN.
- id_ecall, DRAIN_CYCLES=3 -> halt=1 on 4th clock edge. ecall_ack pulse after 10 cycles -> flush_id=1, stall_if=0 for that cycle, halt=0 next cycle.
- Assert rst during DRAIN (cnt=1) -> halt=0, all outputs at RUN values. Under HAZARD_PERF_EN, counters read 0.
